// File: rtl/grid_port_arbiter.sv
// grid_port_arbiter
//   Shares one single-port grid RAM (1-cycle read latency) between a video
//   reader, a grid clear engine and game read/write ports.
//   Priority: video > clear (CLEAR state) > game read/write (SERVE state,
//   round-robin between read and write).
// Ports:
//   clk, rst                         clock, async active-high reset
//   vid_req/vid_x/vid_y              video cell read, always granted
//   vid_data/vid_valid               video result, one cycle after grant
//   rd_req/rd_x/rd_y/rd_ack          game read request and grant
//   rd_data/rd_valid                 game read result, one cycle after ack
//   wr_req/wr_x/wr_y/wr_data/wr_ack  game write request and grant
//   clr_start/clr_busy/clr_done      grid clear control and status
//   mem_addr/mem_we/mem_wdata/mem_rdata  grid RAM port, address {y,x}
module grid_port_arbiter #(
  parameter int unsigned GRID_X    = 32,
  parameter int unsigned GRID_Y    = 24,
  parameter logic [3:0]  NULL_CODE = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vid_req,
  input  logic [4:0] vid_x,
  input  logic [4:0] vid_y,
  output logic [3:0] vid_data,
  output logic       vid_valid,
  input  logic       rd_req,
  input  logic [4:0] rd_x,
  input  logic [4:0] rd_y,
  output logic       rd_ack,
  output logic [3:0] rd_data,
  output logic       rd_valid,
  input  logic       wr_req,
  input  logic [4:0] wr_x,
  input  logic [4:0] wr_y,
  input  logic [3:0] wr_data,
  output logic       wr_ack,
  input  logic       clr_start,
  output logic       clr_busy,
  output logic       clr_done,
  output logic [9:0] mem_addr,
  output logic       mem_we,
  output logic [3:0] mem_wdata,
  input  logic [3:0] mem_rdata
);

  localparam int unsigned CW = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cx_q, cx_d;
  logic [CW-1:0] cy_q, cy_d;
  logic          rr_wr_q, rr_wr_d;      // 1: write wins the next tie
  logic          vid_valid_q, vid_valid_d;
  logic          vid_oor_q, vid_oor_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_oor_q, rd_oor_d;
  logic          clr_done_q, clr_done_d;
  logic          grant_rd_c, grant_wr_c;

  // Cell lies outside the populated grid.
  function automatic logic out_of_range(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return (32'(x) >= GRID_X) || (32'(y) >= GRID_Y);
  endfunction

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      cx_q        <= '0;
      cy_q        <= '0;
      rr_wr_q     <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_oor_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_oor_q    <= 1'b0;
      clr_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      rr_wr_q     <= rr_wr_d;
      vid_valid_q <= vid_valid_d;
      vid_oor_q   <= vid_oor_d;
      rd_valid_q  <= rd_valid_d;
      rd_oor_q    <= rd_oor_d;
      clr_done_q  <= clr_done_d;
    end
  end

  // Grant arbitration, RAM port drive and next state.
  always_comb begin
    state_d     = state_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    rr_wr_d     = rr_wr_q;
    vid_valid_d = 1'b0;
    vid_oor_d   = 1'b0;
    rd_valid_d  = 1'b0;
    rd_oor_d    = 1'b0;
    clr_done_d  = 1'b0;
    grant_rd_c  = 1'b0;
    grant_wr_c  = 1'b0;
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    rd_ack      = 1'b0;
    wr_ack      = 1'b0;

    // Reset holds the RAM port and the handshakes quiet.
    if (!rst) begin
      if (vid_req) begin
        mem_addr    = {vid_y, vid_x};
        vid_valid_d = 1'b1;
        vid_oor_d   = out_of_range(vid_x, vid_y);
      end else if (state_q == ST_CLEAR) begin
        mem_addr  = {cy_q, cx_q};
        mem_we    = 1'b1;
        mem_wdata = NULL_CODE;
        if (cx_q == CW'(GRID_X - 1)) begin
          cx_d = '0;
          if (cy_q == CW'(GRID_Y - 1)) begin
            cy_d       = '0;
            state_d    = ST_SERVE;
            clr_done_d = 1'b1;
          end else begin
            cy_d = cy_q + CW'(1);
          end
        end else begin
          cx_d = cx_q + CW'(1);
        end
      end else begin
        grant_rd_c = rd_req && (!wr_req || !rr_wr_q);
        grant_wr_c = wr_req && !grant_rd_c;
        if (grant_rd_c) begin
          mem_addr   = {rd_y, rd_x};
          rd_ack     = 1'b1;
          rd_valid_d = 1'b1;
          rd_oor_d   = out_of_range(rd_x, rd_y);
          rr_wr_d    = 1'b1;
        end else if (grant_wr_c) begin
          mem_addr  = {wr_y, wr_x};
          mem_we    = !out_of_range(wr_x, wr_y);
          mem_wdata = wr_data;
          wr_ack    = 1'b1;
          rr_wr_d   = 1'b0;
        end
      end

      // A grant in the same cycle still completes; the clear starts next cycle.
      if ((state_q == ST_SERVE) && clr_start) begin
        state_d = ST_CLEAR;
        cx_d    = '0;
        cy_d    = '0;
      end
    end
  end

  // Read data arrives with the valid, straight from the RAM.
  assign vid_valid = vid_valid_q;
  assign vid_data  = vid_valid_q ? (vid_oor_q ? NULL_CODE : mem_rdata) : '0;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_valid_q ? (rd_oor_q ? NULL_CODE : mem_rdata) : '0;
  assign clr_busy  = (state_q == ST_CLEAR);
  assign clr_done  = clr_done_q;

endmodule

// File: tb/tb_grid_port_arbiter.sv
// Directed bench for grid_port_arbiter with a behavioural 1-cycle-latency RAM.
module tb_grid_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       vid_req, rd_req, wr_req, clr_start;
  logic [4:0] vid_x, vid_y, rd_x, rd_y, wr_x, wr_y;
  logic [3:0] wr_data;
  logic [3:0] vid_data, rd_data;
  logic       vid_valid, rd_valid, rd_ack, wr_ack, clr_busy, clr_done;
  logic [9:0] mem_addr;
  logic       mem_we;
  logic [3:0] mem_wdata;
  logic [3:0] mem_rdata;
  logic       tb_poke;
  logic [3:0] ram [0:1023];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  grid_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .vid_req   (vid_req),
    .vid_x     (vid_x),
    .vid_y     (vid_y),
    .vid_data  (vid_data),
    .vid_valid (vid_valid),
    .rd_req    (rd_req),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .wr_req    (wr_req),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Single-port RAM, read-before-write; tb_poke marks the first off-grid cell.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    else if (tb_poke) ram[768] <= 4'hF;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    vid_req = 1'b0; rd_req = 1'b0; wr_req = 1'b0; clr_start = 1'b0;
  endtask

  // Runs a whole clear starting at the current negedge; video held over
  // cycles [vs,ve) at cell (5,3) expecting vdata; clr_start pulsed at cycle 100.
  task automatic run_clear(input int vs, input int ve, input logic hold_rd, input logic [3:0] vdata);
    int   c = 0, e = 0, bad_wr = 0, bad_ctl = 0, bad_vid = 0, pulses = 0;
    logic was_vid = 1'b0;
    while (e < 768 && c < 2000) begin
      vid_req = (c >= vs) && (c < ve); vid_x = 5'd5; vid_y = 5'd3;
      clr_start = (c == 100);
      rd_req = hold_rd; rd_x = 5'd1; rd_y = 5'd0;
      #1;
      if (vid_req) begin
        if (mem_we !== 1'b0 || mem_addr !== 10'd101) bad_wr++;
      end else begin
        if (mem_we !== 1'b1 || mem_addr !== 10'(e) || mem_wdata !== 4'h0) bad_wr++;
        e++;
      end
      if (rd_ack !== 1'b0 || wr_ack !== 1'b0 || clr_busy !== 1'b1 || clr_done !== 1'b0) bad_ctl++;
      if (vid_valid !== was_vid) bad_vid++;
      if (vid_valid === 1'b1) begin
        pulses++;
        if (vid_data !== vdata) bad_vid++;
      end
      was_vid = vid_req;
      @(negedge clk);
      c++;
    end
    vid_req = 1'b0; clr_start = 1'b0;
    #1;
    chk("clr_writes_done", 32'(e), 32'd768);
    chk("clr_write_seq_bad", 32'(bad_wr), 32'd0);
    chk("clr_ctrl_bad", 32'(bad_ctl), 32'd0);
    chk("clr_vid_bad", 32'(bad_vid), 32'd0);
    chk("clr_vid_pulses", 32'(pulses), 32'(ve - vs));
    chk("clr_length", 32'(c), 32'(768 + ve - vs));
    chk("clr_done_pulse", 32'(clr_done), 32'd1);
    chk("clr_busy_low", 32'(clr_busy), 32'd0);
    chk("clr_done_mem_we", 32'(mem_we), 32'd0);
    chk("clr_pending_rd_ack", 32'(rd_ack), 32'(hold_rd));
  endtask

  initial begin
    // Reset with every request raised: nothing may be granted.
    rst = 1'b1; tb_poke = 1'b1;
    vid_req = 1'b1; rd_req = 1'b1; wr_req = 1'b1; clr_start = 1'b0;
    vid_x = 5'd0; vid_y = 5'd0; rd_x = 5'd0; rd_y = 5'd0;
    wr_x = 5'd0; wr_y = 5'd0; wr_data = 4'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_clr_busy", 32'(clr_busy), 32'd1);
    chk("rst_clr_done", 32'(clr_done), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_rd_ack", 32'(rd_ack), 32'd0);
    chk("rst_wr_ack", 32'(wr_ack), 32'd0);
    chk("rst_vid_valid", 32'(vid_valid), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", 32'({rd_data, vid_data}), 32'd0);
    @(negedge clk);
    idle(); tb_poke = 1'b0; rst = 1'b0;

    // Full clear from reset.
    run_clear(0, 0, 1'b0, 4'h0);
    @(negedge clk); idle(); #1;
    chk("post_clr_done_low", 32'(clr_done), 32'd0);
    chk("post_clr_busy_low", 32'(clr_busy), 32'd0);

    // Both game requests held: R,W,R,W with pointer from reset.
    @(negedge clk);
    rd_req = 1'b1; rd_x = 5'd1; rd_y = 5'd0;
    wr_req = 1'b1; wr_x = 5'd1; wr_y = 5'd0; wr_data = 4'hA;
    #1;
    chk("rr1_rd_ack", 32'({rd_ack, wr_ack}), 32'b10);
    @(negedge clk); #1;
    chk("rr2_wr_ack", 32'({rd_ack, wr_ack}), 32'b01);
    chk("rr2_mem_we", 32'(mem_we), 32'd1);
    chk("rr2_rd_valid", 32'(rd_valid), 32'd1);
    chk("rr2_rd_data", 32'(rd_data), 32'h0);
    @(negedge clk); #1;
    chk("rr3_rd_ack", 32'({rd_ack, wr_ack}), 32'b10);
    @(negedge clk); #1;
    chk("rr4_wr_ack", 32'({rd_ack, wr_ack}), 32'b01);
    chk("rr4_rd_valid", 32'(rd_valid), 32'd1);
    chk("rr4_rd_data", 32'(rd_data), 32'hA);
    @(negedge clk); idle(); #1;
    chk("rr_no_valid_after_wr", 32'(rd_valid), 32'd0);

    // Write then read back cell (5,3).
    @(negedge clk);
    wr_req = 1'b1; wr_x = 5'd5; wr_y = 5'd3; wr_data = 4'b0100;
    #1;
    chk("wr_ack", 32'(wr_ack), 32'd1);
    chk("wr_mem_addr", 32'(mem_addr), 32'd101);
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'h4);
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b1; rd_x = 5'd5; rd_y = 5'd3;
    #1;
    chk("rd_ack", 32'(rd_ack), 32'd1);
    chk("rd_mem_we", 32'(mem_we), 32'd0);
    chk("rd_mem_addr", 32'(mem_addr), 32'd101);
    @(negedge clk); rd_req = 1'b0; #1;
    chk("rd_valid", 32'(rd_valid), 32'd1);
    chk("rd_data", 32'(rd_data), 32'h4);

    // Video beats a game read; the read is served next cycle.
    @(negedge clk);
    vid_req = 1'b1; vid_x = 5'd5; vid_y = 5'd3;
    rd_req = 1'b1; rd_x = 5'd1; rd_y = 5'd0;
    #1;
    chk("vp_rd_blocked", 32'(rd_ack), 32'd0);
    chk("vp_mem_addr", 32'(mem_addr), 32'd101);
    @(negedge clk); vid_req = 1'b0; #1;
    chk("vp_vid_valid", 32'(vid_valid), 32'd1);
    chk("vp_vid_data", 32'(vid_data), 32'h4);
    chk("vp_rd_ack", 32'(rd_ack), 32'd1);
    chk("vp_rd_addr", 32'(mem_addr), 32'd1);
    @(negedge clk); rd_req = 1'b0; #1;
    chk("vp_rd_data", 32'(rd_data), 32'hA);
    chk("vp_vid_valid_once", 32'(vid_valid), 32'd0);

    // Off-grid accesses: acked, no write, NULL data.
    @(negedge clk);
    rd_req = 1'b1; rd_x = 5'd0; rd_y = 5'd24;
    #1;
    chk("oor_rd_ack", 32'(rd_ack), 32'd1);
    chk("oor_rd_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b1; wr_x = 5'd0; wr_y = 5'd24; wr_data = 4'h5;
    #1;
    chk("oor_rd_valid", 32'(rd_valid), 32'd1);
    chk("oor_rd_data", 32'(rd_data), 32'h0);
    chk("oor_wr_ack", 32'(wr_ack), 32'd1);
    chk("oor_wr_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    wr_req = 1'b0; vid_req = 1'b1; vid_x = 5'd0; vid_y = 5'd24;
    @(negedge clk); vid_req = 1'b0; #1;
    chk("oor_vid_valid", 32'(vid_valid), 32'd1);
    chk("oor_vid_data", 32'(vid_data), 32'h0);

    // clr_start alongside a write grant: the write completes, then clear
    // with 10 video stall cycles and a game read left pending.
    @(negedge clk);
    wr_req = 1'b1; wr_x = 5'd2; wr_y = 5'd0; wr_data = 4'h7; clr_start = 1'b1;
    #1;
    chk("cs_wr_ack", 32'(wr_ack), 32'd1);
    chk("cs_mem_we", 32'(mem_we), 32'd1);
    chk("cs_mem_addr", 32'(mem_addr), 32'd2);
    chk("cs_busy_still_low", 32'(clr_busy), 32'd0);
    @(negedge clk); wr_req = 1'b0; clr_start = 1'b0;
    run_clear(5, 15, 1'b1, 4'h4);
    @(negedge clk); idle(); #1;
    chk("cs_rd_valid", 32'(rd_valid), 32'd1);
    chk("cs_rd_data_cleared", 32'(rd_data), 32'h0);

    // Reset at clear counter 300 abandons the clear and a video read.
    @(negedge clk); clr_start = 1'b1;
    @(negedge clk); clr_start = 1'b0;
    for (int i = 0; i < 300; i++) @(negedge clk);
    #1;
    chk("mid_clr_addr", 32'(mem_addr), 32'd300);
    chk("mid_clr_we", 32'(mem_we), 32'd1);
    @(negedge clk); vid_req = 1'b1; vid_x = 5'd5; vid_y = 5'd3;
    @(negedge clk); rst = 1'b1; vid_req = 1'b0; #1;
    chk("mid_rst_vid_valid", 32'(vid_valid), 32'd0);
    chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
    chk("mid_rst_busy", 32'(clr_busy), 32'd1);
    @(negedge clk); rst = 1'b0;
    run_clear(0, 0, 1'b0, 4'h0);
    @(negedge clk); idle(); #1;
    chk("final_busy_low", 32'(clr_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grid_port_arbiter.md
GRID_PORT_ARBITER -- requirements
Module: grid_port_arbiter

Interface
REQ-001 SHALL have parameter: GRID_X, 32, grid columns (x coordinate range 0..GRID_X-1).
REQ-002 SHALL have parameter: GRID_Y, 24, grid rows (y coordinate range 0..GRID_Y-1).
REQ-003 SHALL have parameter: NULL_CODE, 4'b0000, cell code written by the clear engine.
REQ-004 SHALL use reset rst, asynchronous, active-high, and clock clk.
REQ-005 SHALL have port: clk  input  1  system clock.
REQ-006 SHALL have port: rst  input  1  async active-high reset.
REQ-007 SHALL have ports: vid_req input 1, vid_x input 5, vid_y input 5  video renderer cell read request.
REQ-008 SHALL have ports: vid_data output 4, vid_valid output 1  video read result.
REQ-009 SHALL have ports: rd_req input 1, rd_x input 5, rd_y input 5, rd_ack output 1  game read request and grant.
REQ-010 SHALL have ports: rd_data output 4, rd_valid output 1  game read result.
REQ-011 SHALL have ports: wr_req input 1, wr_x input 5, wr_y input 5, wr_data input 4, wr_ack output 1  game cell write request and grant.
REQ-012 SHALL have ports: clr_start input 1, clr_busy output 1, clr_done output 1  grid clear control.
REQ-013 SHALL have ports: mem_addr output 10, mem_we output 1, mem_wdata output 4, mem_rdata input 4  single-port grid RAM with 1-cycle read latency.

Function
REQ-014 SHALL map cell (x,y) to mem_addr = {y[4:0], x[4:0]}.
REQ-015 SHALL issue at most one RAM access per cycle; grant decision is combinational on the current requests, outputs mem_* registered-free (driven in the grant cycle).
REQ-016 SHALL implement states CLEAR and SERVE; reset enters CLEAR with clear counter 0.
REQ-017 SHALL give priority: video > clear (in CLEAR) > game read/write (in SERVE only).
REQ-018 SHALL grant vid_req in every cycle it is high; vid_valid SHALL pulse exactly 1 cycle later with vid_data = mem_rdata.
REQ-019 SHALL, in SERVE with no video request, arbitrate rd_req vs wr_req round-robin: when both are pending, grant the one not granted last; a lone request is granted immediately.
REQ-020 SHALL pulse rd_ack/wr_ack for exactly the grant cycle; requesters hold req and operands stable until ack; req high in the cycle after ack counts as a new request.
REQ-021 SHALL pulse rd_valid 1 cycle after rd_ack with rd_data = mem_rdata.
REQ-022 SHALL drive mem_we=1, mem_wdata=wr_data in a write grant cycle; mem_we=0 otherwise except clear writes.
REQ-023 SHALL treat y >= GRID_Y or x >= GRID_X as out of range: writes acked but mem_we=0; reads acked and rd_data/vid_data forced to NULL_CODE at valid.
REQ-024 SHALL in CLEAR write NULL_CODE to address of counter cell (x,y), scanning x 0..GRID_X-1 then y, one cell per cycle without video request; stalls while vid_req high.
REQ-025 SHALL hold clr_busy=1 throughout CLEAR and never ack game requests in CLEAR (they stay pending).
REQ-026 SHALL, after writing cell (GRID_X-1,GRID_Y-1), pulse clr_done 1 cycle, drop clr_busy, enter SERVE next cycle.
REQ-027 SHALL on clr_start in SERVE enter CLEAR next cycle with counter 0; clr_start while in CLEAR SHALL be ignored (no restart).
REQ-028 SHALL, if clr_start coincides with a game grant, complete that grant (ack and valid as normal) before clearing.
REQ-029 SHALL complete a full clear in GRID_X*GRID_Y = 768 cycles plus stalled video cycles.

Reset
REQ-030 SHALL on rst assertion immediately force: state CLEAR, counter 0, clr_busy=1, clr_done=0, rd_ack=wr_ack=0, rd_valid=vid_valid=0, rd_data=vid_data=0, round-robin pointer to "read next", mem_we=0.
REQ-031 SHALL, on rst asserted mid-clear or mid-transaction, abandon it; no ack or valid issued for the abandoned access.

Verification
REQ-032 Reset release, no requests -> 768 consecutive mem_we=1 with mem_wdata=0, addresses 0..(23<<5|31) skipping x>=32 gaps none, clr_done pulse at cycle 768, clr_busy low after.
REQ-033 SERVE, wr_req (x=5,y=3,data=4'b0100) -> wr_ack same cycle, mem_addr=10'd101, mem_we=1; then rd_req same cell -> rd_valid next cycle, rd_data=4'b0100.
REQ-034 rd_req and wr_req held high together for 4 cycles -> grants alternate R,W,R,W (pointer from reset), one ack per cycle.
REQ-035 vid_req held 10 cycles during CLEAR -> clear counter frozen, vid_valid 10 pulses, total clear length 778 cycles.
REQ-036 rd_req at (x=0,y=24) -> rd_ack, rd_valid next cycle with rd_data=0, mem_we=0; rst mid-clear at counter 300 -> clear restarts from 0, clr_done only after full 768 writes.
